// File: rtl/model_cpu_cpu_ocimem_arbiter.sv
// Sysclk-side arbiter sharing the single-port OCI debug RAM between the
// JTAG debug path (one-deep command queue) and the CPU debug Avalon slave.
module model_cpu_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_JTAG} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  typedef enum logic {GNT_JTAG, GNT_CPU} grant_t;

  state_t              state_q, state_d;
  op_t                 pend_op;
  grant_t              last_grant;
  logic [ADDR_W-1:0]   jtag_addr;
  logic                jtag_pend;
  logic [DATA_W-1:0]   pend_data;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [DATA_W-1:0]   avs_readdata_q;

  logic cpu_req, gnt_cpu, gnt_jtag, cpu_ack, jtag_done;
  logic any_strobe, queue_wr, queue_rd;
  logic unused_jdo;

  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  assign cpu_req    = avs_read | avs_write;
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign queue_wr   = take_action_ocimem_b;
  assign queue_rd   = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[35]);

  // RAM-side outputs are bypass muxes over hold registers: a grant drives the
  // RAM in the same cycle, otherwise the last driven value is held.
  always_comb begin
    state_d      = state_q;
    gnt_cpu      = 1'b0;
    gnt_jtag     = 1'b0;
    cpu_ack      = 1'b0;
    jtag_done    = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = ram_addr_q;
    ram_wdata    = ram_wdata_q;
    avs_readdata = avs_readdata_q;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          gnt_cpu  = cpu_req & (~jtag_pend | (last_grant == GNT_JTAG));
          gnt_jtag = jtag_pend & ~gnt_cpu;
          if (gnt_cpu) begin
            ram_addr = avs_address;
            if (avs_write) begin
              ram_we    = 1'b1;
              ram_wdata = avs_writedata;
              cpu_ack   = 1'b1;
            end else begin
              state_d = RD_CPU;
            end
          end else if (gnt_jtag) begin
            ram_addr = jtag_addr;
            if (pend_op == OP_WR) begin
              ram_we    = 1'b1;
              ram_wdata = pend_data;
              jtag_done = 1'b1;
            end else begin
              state_d = RD_JTAG;
            end
          end
        end
        RD_CPU: begin
          cpu_ack      = 1'b1;
          avs_readdata = ram_rdata;
          state_d      = IDLE;
        end
        RD_JTAG: begin
          jtag_done = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    avs_waitrequest = cpu_req & ~cpu_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      jtag_addr      <= '0;
      jtag_pend      <= 1'b0;
      pend_op        <= OP_RD;
      pend_data      <= '0;
      last_grant     <= GNT_JTAG;
      MonDReg        <= '0;
      monitor_ready  <= 1'b1;
      monitor_error  <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      avs_readdata_q <= '0;
    end else begin
      state_q        <= state_d;
      ram_addr_q     <= ram_addr;
      ram_wdata_q    <= ram_wdata;
      avs_readdata_q <= avs_readdata;

      if (gnt_cpu)       last_grant <= GNT_CPU;
      else if (gnt_jtag) last_grant <= GNT_JTAG;

      if (state_q == RD_JTAG) MonDReg <= ram_rdata;

      if (jtag_done) begin
        jtag_pend     <= 1'b0;
        jtag_addr     <= jtag_addr + ADDR_W'(1);
        monitor_ready <= 1'b1;
      end

      // Strobes are judged against the pre-completion pending flag, so a
      // strobe landing on the completion cycle is still an overrun.
      if (any_strobe) begin
        if (jtag_pend) begin
          monitor_error <= 1'b1;
        end else begin
          if (take_action_ocimem_a) jtag_addr <= ADDR_W'(jdo[17:10]);
          if (queue_wr | queue_rd) begin
            jtag_pend     <= 1'b1;
            pend_op       <= queue_wr ? OP_WR : OP_RD;
            monitor_ready <= 1'b0;
            if (queue_wr) pend_data <= jdo[34:3];
          end
        end
      end
    end
  end

endmodule
